// File: rtl/sa_out_collector_8bit.sv
// -----------------------------------------------------------------------------
// sa_out_collector_8bit
//
// Collects the skewed output of a systolic array, de-skews it into whole rows
// and assembles the complete X_R x N byte matrix.
//
// Element (r,c) arrives on column c of I_SA_OUT LAT+r+c cycles after the start
// cycle. Column c is delayed by N-1-c registers plus a common output register,
// so every byte of row r lines up on O_ROW LAT+N+r cycles after start.
//
// Parameters
//   N    : number of array output columns (8 bits each)
//   X_R  : number of result rows per matrix
//   LAT  : start-to-element(0,0) latency in cycles, >= 1
//
// Ports
//   I_CLK        : clock, rising edge
//   I_RST_N      : asynchronous active-low reset
//   I_START_FLAG : one-cycle start pulse, aborts any running job
//   I_SA_OUT     : skewed array output, column c at [c*8 +: 8]
//   O_ROW_VLD    : one-cycle strobe per de-skewed row
//   O_ROW        : de-skewed row, column c at [c*8 +: 8]
//   O_ROW_IDX    : index of the row currently on O_ROW
//   O_MATRIX     : full result, element (r,c) at [(r*N+c)*8 +: 8]
//   O_BUSY       : high while waiting for or collecting rows
//   O_DONE       : one-cycle pulse after the last row has been stored
//
// State table
//   state     | meaning
//   S_IDLE    | no job, waiting for start
//   S_WAIT    | job started, counting down array latency plus skew
//   S_COLLECT | one de-skewed row valid per cycle, stored into the matrix
//   S_DONE    | last row stored, done pulse
// -----------------------------------------------------------------------------
module sa_out_collector_8bit #(
  parameter int N   = 64,
  parameter int X_R = 64,
  parameter int LAT = 64
) (
  input  logic                                  I_CLK,
  input  logic                                  I_RST_N,
  input  logic                                  I_START_FLAG,
  input  logic [N*8-1:0]                        I_SA_OUT,
  output logic                                  O_ROW_VLD,
  output logic [N*8-1:0]                        O_ROW,
  output logic [((X_R > 1) ? $clog2(X_R) : 1)-1:0] O_ROW_IDX,
  output logic [X_R*N*8-1:0]                    O_MATRIX,
  output logic                                  O_BUSY,
  output logic                                  O_DONE
);

  localparam int IDX_W = (X_R > 1) ? $clog2(X_R) : 1;
  localparam int CNT_W = $clog2(LAT + N + X_R + 1);

  // The counter holds k in cycle T0+k; the first row is registered on the
  // edge that ends cycle T0+LAT+N-1.
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(LAT + N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(X_R - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [IDX_W-1:0]   row_idx_q, row_idx_d;
  logic [N*8-1:0]     row_q,     row_d;
  logic [X_R*N*8-1:0] matrix_q,  matrix_d;

  // ---------------------------------------------------------------------------
  // De-skew delay lines: column c gets N-1-c stages, the last column none.
  // They shift every cycle regardless of state.
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < N; c++) begin : g_col
    localparam int DEPTH = N - 1 - c;
    if (DEPTH == 0) begin : g_direct
      assign row_d[c*8 +: 8] = I_SA_OUT[c*8 +: 8];
    end else begin : g_chain
      logic [7:0] chain_q [DEPTH];
      logic [7:0] chain_d [DEPTH];

      always_comb begin
        chain_d[0] = I_SA_OUT[c*8 +: 8];
        for (int k = 1; k < DEPTH; k++) begin
          chain_d[k] = chain_q[k-1];
        end
      end

      always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
          for (int k = 0; k < DEPTH; k++) begin
            chain_q[k] <= '0;
          end
        end else begin
          for (int k = 0; k < DEPTH; k++) begin
            chain_q[k] <= chain_d[k];
          end
        end
      end

      assign row_d[c*8 +: 8] = chain_q[DEPTH-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_idx_d = row_idx_q;

    if (state_q != S_IDLE && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_WAIT: begin
        if (cnt_q == CNT_FIRST) begin
          state_d   = S_COLLECT;
          row_idx_d = '0;
        end
      end
      S_COLLECT: begin
        if (row_idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          row_idx_d = row_idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A start in any state (including DONE) restarts timing from this cycle.
    if (I_START_FLAG) begin
      state_d   = S_WAIT;
      cnt_d     = CNT_W'(1);
      row_idx_d = '0;
    end
  end

  // The row on O_ROW is stored in the same cycle it is flagged valid, even if
  // a start arrives in that cycle.
  always_comb begin
    matrix_d = matrix_q;
    if (state_q == S_COLLECT) begin
      for (int r = 0; r < X_R; r++) begin
        if (row_idx_q == IDX_W'(r)) begin
          matrix_d[r*N*8 +: N*8] = row_q;
        end
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      row_idx_q <= '0;
      row_q     <= '0;
      matrix_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_idx_q <= row_idx_d;
      row_q     <= row_d;
      matrix_q  <= matrix_d;
    end
  end

  assign O_ROW_VLD = (state_q == S_COLLECT);
  assign O_ROW     = row_q;
  assign O_ROW_IDX = row_idx_q;
  assign O_MATRIX  = matrix_q;
  assign O_BUSY    = (state_q == S_WAIT) || (state_q == S_COLLECT);
  assign O_DONE    = (state_q == S_DONE);

endmodule

// File: tb/tb_sa_out_collector_8bit.sv
// -----------------------------------------------------------------------------
// Testbench for sa_out_collector_8bit (N=4, X_R=3, LAT=2).
// The reference model tracks the most recent start cycle and derives every
// expected output from the timing rules: rows at T0+LAT+N+r, done at
// T0+LAT+N+X_R, busy in between. A start supersedes the previous job; reset
// discards it.
// -----------------------------------------------------------------------------
module tb_sa_out_collector_8bit;

  localparam int N   = 4;
  localparam int X_R = 3;
  localparam int LAT = 2;
  localparam int W   = N * 8;
  localparam int MW  = X_R * N * 8;
  localparam int IW  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  sa_out;
  logic          row_vld;
  logic [W-1:0]  row;
  logic [IW-1:0] row_idx;
  logic [MW-1:0] matrix;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  sa_out_collector_8bit #(.N(N), .X_R(X_R), .LAT(LAT)) dut (
    .I_CLK        (clk),
    .I_RST_N      (rst_n),
    .I_START_FLAG (start),
    .I_SA_OUT     (sa_out),
    .O_ROW_VLD    (row_vld),
    .O_ROW        (row),
    .O_ROW_IDX    (row_idx),
    .O_MATRIX     (matrix),
    .O_BUSY       (busy),
    .O_DONE       (done)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  int            job_t0 = -1000;
  bit            job_valid = 1'b0;
  int            mode   = 0;      // 0: r*16+c, 1: 80/FF by column, 2: random
  logic [7:0]    elem [X_R][N];
  logic [MW-1:0] mat_exp = '0;

  function automatic logic [2:0] e_ctrl();
    int d;
    d = cyc - job_t0;
    if (!job_valid) return 3'b000;
    return {(d >= 1 && d <= LAT + N + X_R - 1),
            (d >= LAT + N && d <= LAT + N + X_R - 1),
            (d == LAT + N + X_R)};
  endfunction

  function automatic bit e_vld();
    int d;
    d = cyc - job_t0;
    return job_valid && d >= LAT + N && d <= LAT + N + X_R - 1;
  endfunction

  function automatic logic [IW+W-1:0] e_row();
    logic [W-1:0] v;
    int r;
    r = cyc - job_t0 - LAT - N;
    v = '0;
    if (r >= 0 && r < X_R)
      for (int c = 0; c < N; c++) v[c*8 +: 8] = elem[r][c];
    return {IW'(r), v};
  endfunction

  // Drive one cycle: record the row stored this cycle, optionally start a new
  // job, place the newest job's elements at their skewed slots, then advance.
  task automatic step(input bit st);
    int r;
    if (e_vld()) begin
      r = cyc - job_t0 - LAT - N;
      for (int c = 0; c < N; c++) mat_exp[(r*N + c)*8 +: 8] = elem[r][c];
    end
    if (st) begin
      job_t0    = cyc;
      job_valid = 1'b1;
      for (int rr = 0; rr < X_R; rr++)
        for (int c = 0; c < N; c++)
          case (mode)
            0:       elem[rr][c] = 8'(rr * 16 + c);
            1:       elem[rr][c] = (c % 2 == 0) ? 8'h80 : 8'hFF;
            default: elem[rr][c] = 8'($urandom);
          endcase
    end
    start = st;
    for (int c = 0; c < N; c++) begin
      r = cyc - job_t0 - LAT - c;
      if (job_valid && r >= 0 && r < X_R) sa_out[c*8 +: 8] = elem[r][c];
      else                               sa_out[c*8 +: 8] = 8'($urandom);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; sa_out = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, row_vld, done, row_idx, row, matrix} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b vld=%b done=%b idx=%0d row=%h mat_nonzero=%b want all 0",
               busy, row_vld, done, row_idx, row, |matrix);
    end
    step(0); step(0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy, row_vld, done} !== 3'b000) begin
        errors++;
        $display("FAIL reset_release cyc=%0d busy/vld/done got %b want 000", cyc, {busy, row_vld, done});
      end
      step(0);
    end
  endtask

  task automatic test_basic();
    int t0;
    mode = 0;
    t0 = cyc;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({busy, row_vld, done} !== e_ctrl()) begin
        errors++;
        $display("FAIL basic_ctrl cyc=T0+%0d busy/vld/done got %b want %b", cyc - t0, {busy, row_vld, done}, e_ctrl());
      end
      if (e_vld()) begin
        checks++;
        if ({row_idx, row} !== e_row()) begin
          errors++;
          $display("FAIL basic_row cyc=T0+%0d idx/row got %h want %h", cyc - t0, {row_idx, row}, e_row());
        end
      end
      checks++;
      if (matrix !== mat_exp) begin
        errors++;
        $display("FAIL basic_matrix cyc=T0+%0d got %h want %h", cyc - t0, matrix, mat_exp);
      end
      if (cyc == t0 + 7) begin
        checks++;
        if ({row_vld, row} !== {1'b1, 32'h13121110}) begin
          errors++;
          $display("FAIL basic_row1 got vld=%b row=%h want vld=1 row=13121110", row_vld, row);
        end
      end
      if (cyc == t0 + 9) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL basic_done_time got %b want 1 at T0+9", done);
        end
      end
      step(i == 0);
    end
    checks++;
    if (matrix[(2*4 + 3)*8 +: 8] !== 8'h23) begin
      errors++;
      $display("FAIL basic_elem23 got %h want 23", matrix[(2*4 + 3)*8 +: 8]);
    end
  endtask

  task automatic test_signed();
    mode = 1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({busy, row_vld, done} !== e_ctrl()) begin
        errors++;
        $display("FAIL signed_ctrl cyc=%0d busy/vld/done got %b want %b", cyc, {busy, row_vld, done}, e_ctrl());
      end
      if (e_vld()) begin
        checks++;
        if (row !== 32'hFF80FF80) begin
          errors++;
          $display("FAIL signed_row cyc=%0d got %h want ff80ff80", cyc, row);
        end
      end
      step(i == 0);
    end
    checks++;
    if (matrix !== mat_exp) begin
      errors++;
      $display("FAIL signed_matrix got %h want %h", matrix, mat_exp);
    end
  endtask

  task automatic test_restart();
    int t0;
    int done_cnt;
    int first_vld;
    mode = 2;
    t0 = cyc;
    done_cnt = 0;
    first_vld = -1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({busy, row_vld, done} !== e_ctrl()) begin
        errors++;
        $display("FAIL restart_ctrl cyc=T0+%0d busy/vld/done got %b want %b", cyc - t0, {busy, row_vld, done}, e_ctrl());
      end
      if (e_vld()) begin
        checks++;
        if ({row_idx, row} !== e_row()) begin
          errors++;
          $display("FAIL restart_row cyc=T0+%0d idx/row got %h want %h", cyc - t0, {row_idx, row}, e_row());
        end
      end
      if (cyc == t0 + 6) begin
        checks++;
        if (row_vld !== 1'b0) begin
          errors++;
          $display("FAIL restart_no_old_row got vld=%b want 0 at T0+6", row_vld);
        end
      end
      if (done === 1'b1) done_cnt++;
      if (row_vld === 1'b1 && first_vld < 0) first_vld = cyc - t0;
      step(i == 0 || i == 4);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL restart_done_count got %0d want 1", done_cnt);
    end
    checks++;
    if (first_vld !== 10) begin
      errors++;
      $display("FAIL restart_first_row got T0+%0d want T0+10", first_vld);
    end
  endtask

  task automatic test_reset_midjob();
    int done_cnt;
    mode = 2;
    done_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({busy, row_vld, done} !== e_ctrl()) begin
        errors++;
        $display("FAIL midrst_ctrl cyc=%0d busy/vld/done got %b want %b", cyc, {busy, row_vld, done}, e_ctrl());
      end
      step(i == 0);
    end
    #2 rst_n = 1'b0;
    #1;
    job_valid = 1'b0;
    mat_exp   = '0;
    checks++;
    if ({busy, row_vld, done, row_idx, row, matrix} !== '0) begin
      errors++;
      $display("FAIL midrst_async got busy=%b vld=%b done=%b idx=%0d row=%h mat_nonzero=%b want all 0",
               busy, row_vld, done, row_idx, row, |matrix);
    end
    step(0); step(0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) done_cnt++;
      checks++;
      if ({busy, row_vld, done} !== 3'b000) begin
        errors++;
        $display("FAIL midrst_after cyc=%0d busy/vld/done got %b want 000", cyc, {busy, row_vld, done});
      end
      step(0);
    end
    checks++;
    if (done_cnt !== 0 || matrix !== '0) begin
      errors++;
      $display("FAIL midrst_final done_count=%0d mat_nonzero=%b want 0 and 0", done_cnt, |matrix);
    end
  endtask

  task automatic test_back_to_back();
    int vld_cnt;
    int first_vld;
    int last_vld;
    mode = 0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if ({busy, row_vld, done} !== e_ctrl()) begin
        errors++;
        $display("FAIL b2b_ctrl1 cyc=%0d busy/vld/done got %b want %b", cyc, {busy, row_vld, done}, e_ctrl());
      end
      step(i == 0);
    end
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_done_cycle busy/done got %b want 01", {busy, done});
    end
    mode = 2;
    step(1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy_next got %b want 1", busy);
    end
    vld_cnt = 0; first_vld = -1; last_vld = -1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({busy, row_vld, done} !== e_ctrl()) begin
        errors++;
        $display("FAIL b2b_ctrl2 cyc=%0d busy/vld/done got %b want %b", cyc, {busy, row_vld, done}, e_ctrl());
      end
      if (e_vld()) begin
        checks++;
        if ({row_idx, row} !== e_row()) begin
          errors++;
          $display("FAIL b2b_row cyc=%0d idx/row got %h want %h", cyc, {row_idx, row}, e_row());
        end
      end
      if (row_vld === 1'b1) begin
        vld_cnt++;
        if (first_vld < 0) first_vld = cyc;
        last_vld = cyc;
      end
      step(0);
    end
    checks++;
    if (vld_cnt !== 3 || last_vld - first_vld !== 2) begin
      errors++;
      $display("FAIL b2b_rows_contiguous got count=%0d span=%0d want 3 and 2", vld_cnt, last_vld - first_vld);
    end
    checks++;
    if (matrix !== mat_exp) begin
      errors++;
      $display("FAIL b2b_matrix got %h want %h", matrix, mat_exp);
    end
  endtask

  task automatic test_idle_noise();
    for (int i = 0; i < 50; i++) begin
      checks++;
      if ({busy, row_vld, done} !== 3'b000) begin
        errors++;
        $display("FAIL idle_ctrl cyc=%0d busy/vld/done got %b want 000", cyc, {busy, row_vld, done});
      end
      step(0);
    end
    checks++;
    if (matrix !== mat_exp) begin
      errors++;
      $display("FAIL idle_matrix got %h want %h", matrix, mat_exp);
    end
  endtask

  task automatic test_random();
    int len;
    mode = 2;
    for (int j = 0; j < 10; j++) begin
      len = (j == 9) ? 14 : int'($urandom_range(3, 14));
      for (int i = 0; i < len; i++) begin
        checks++;
        if ({busy, row_vld, done} !== e_ctrl()) begin
          errors++;
          $display("FAIL rand_ctrl job=%0d cyc=%0d busy/vld/done got %b want %b", j, cyc, {busy, row_vld, done}, e_ctrl());
        end
        if (e_vld()) begin
          checks++;
          if ({row_idx, row} !== e_row()) begin
            errors++;
            $display("FAIL rand_row job=%0d cyc=%0d idx/row got %h want %h", j, cyc, {row_idx, row}, e_row());
          end
        end
        checks++;
        if (matrix !== mat_exp) begin
          errors++;
          $display("FAIL rand_matrix job=%0d cyc=%0d got %h want %h", j, cyc, matrix, mat_exp);
        end
        step(i == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_restart();
    test_reset_midjob();
    test_back_to_back();
    test_idle_noise();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
